// File: rtl/hazard_unit.sv
// ---------------------------------------------------------------------------
// hazard_unit
//
// Stall and forwarding controller for the five-stage MIPS pipeline. It decodes
// the instruction in the F/D register and keeps a shadow record of every
// in-flight register write in the E, M and W stages. Each record carries the
// destination register (a3) and a Tnew countdown. The countdown gives the
// number of cycles until the result can be forwarded.
//
// Ports
//   clk        in   1   core clock, rising-edge
//   reset      in   1   asynchronous active-high clear of all tracking state
//   instr_d    in  32   instruction held in the F/D register
//   stall      out  1   freeze PC and F/D, bubble into D/E
//   fwd_rs_d   out  2   D operand select: 0 GRF, 1 E link value, 2 M ALU result
//   fwd_rt_d   out  2   same, for rt
//   fwd_rs_e   out  2   ALU operand select: 0 latched, 1 M result, 2 W data
//   fwd_rt_e   out  2   same, for rt
//   fwd_rt_m   out  1   DM write data select: 0 latched, 1 W data
//   stall_cnt  out 32   stall-cycle counter, only when HAZARD_STALL_CNT_EN
//
// Build option
//   HAZARD_STALL_CNT_EN  adds the stall_cnt port and its wrapping counter.
// ---------------------------------------------------------------------------
module hazard_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_d,
    output logic        stall,
    output logic [1:0]  fwd_rs_d,
    output logic [1:0]  fwd_rt_d,
    output logic [1:0]  fwd_rs_e,
    output logic [1:0]  fwd_rt_e,
    output logic        fwd_rt_m
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;
    localparam logic [5:0] FN_JR     = 6'h08;
    localparam logic [5:0] FN_ADD    = 6'h20;
    localparam logic [5:0] FN_SUB    = 6'h22;
    localparam logic [4:0] RT_BGEZAL = 5'h11;

    // Tuse of 3 marks an operand that is never read. It is larger than any
    // Tnew, so such an operand can never stall.
    localparam logic [1:0] TUSE_NONE = 2'd3;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rsD;
    logic [4:0] rtD;
    logic [4:0] rdD;
    logic       unusedShamt;

    assign opcode      = instr_d[31:26];
    assign rsD         = instr_d[25:21];
    assign rtD         = instr_d[20:16];
    assign rdD         = instr_d[15:11];
    assign funct       = instr_d[5:0];
    assign unusedShamt = ^instr_d[10:6];

    logic [1:0] tuseRs;
    logic [1:0] tuseRt;
    logic [4:0] a3D;
    logic [1:0] tnewD;

    // Slot registers. W's Tnew is always 0 by the time it arrives, so W
    // only needs its destination. M keeps rt for the store-data forward.
    logic [4:0] eA3_q, eA3_d;
    logic [1:0] eTnew_q, eTnew_d;
    logic [4:0] eRs_q, eRs_d;
    logic [4:0] eRt_q, eRt_d;
    logic [4:0] mA3_q;
    logic [1:0] mTnew_q;
    logic [4:0] mRt_q;
    logic [4:0] wA3_q;

    function automatic logic hit(input logic [4:0] addr, input logic [4:0] a3);
        return (addr != 5'd0) && (addr == a3);
    endfunction

    function automatic logic [1:0] satDec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    // Instruction decode: operand use times, destination and Tnew at E entry.
    // bgezal writes $31 whether or not the branch is taken. Its rt field is
    // a sub-opcode, not a register read.
    always_comb begin
        tuseRs = TUSE_NONE;
        tuseRt = TUSE_NONE;
        a3D    = 5'd0;
        tnewD  = 2'd0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_SUB: begin
                        tuseRs = 2'd1;
                        tuseRt = 2'd1;
                        a3D    = rdD;
                        tnewD  = 2'd1;
                    end
                    FN_JR: tuseRs = 2'd0;
                    default: ;
                endcase
            end
            OP_ORI: begin
                tuseRs = 2'd1;
                a3D    = rtD;
                tnewD  = 2'd1;
            end
            OP_LUI: begin
                a3D   = rtD;
                tnewD = 2'd1;
            end
            OP_LW: begin
                tuseRs = 2'd1;
                a3D    = rtD;
                tnewD  = 2'd2;
            end
            OP_SW: begin
                tuseRs = 2'd1;
                tuseRt = 2'd2;
            end
            OP_BEQ: begin
                tuseRs = 2'd0;
                tuseRt = 2'd0;
            end
            OP_JAL: a3D = 5'd31;
            OP_REGIMM: begin
                if (rtD == RT_BGEZAL) begin
                    tuseRs = 2'd0;
                    a3D    = 5'd31;
                end
            end
            default: ;
        endcase
    end

    // Stall when a producer in E or M will not have its result ready by the
    // time D's operand is needed. W is always ready, so it is excluded.
    always_comb begin
        logic stallRs;
        logic stallRt;
        stallRs = (hit(rsD, eA3_q) && (eTnew_q > tuseRs)) ||
                  (hit(rsD, mA3_q) && (mTnew_q > tuseRs));
        stallRt = (hit(rtD, eA3_q) && (eTnew_q > tuseRt)) ||
                  (hit(rtD, mA3_q) && (mTnew_q > tuseRt));
        stall   = stallRs | stallRt;
    end

    // D-stage forwarding. Only ready producers are selected, and the nearer
    // stage is checked first. W is covered by GRF write-through.
    always_comb begin
        fwd_rs_d = 2'd0;
        fwd_rt_d = 2'd0;
        if (tuseRs != TUSE_NONE) begin
            if (hit(rsD, eA3_q) && (eTnew_q == 2'd0)) begin
                fwd_rs_d = 2'd1;
            end else if (hit(rsD, mA3_q) && (mTnew_q == 2'd0)) begin
                fwd_rs_d = 2'd2;
            end
        end
        if (tuseRt != TUSE_NONE) begin
            if (hit(rtD, eA3_q) && (eTnew_q == 2'd0)) begin
                fwd_rt_d = 2'd1;
            end else if (hit(rtD, mA3_q) && (mTnew_q == 2'd0)) begin
                fwd_rt_d = 2'd2;
            end
        end
    end

    // E-stage ALU operand and M-stage store-data forwarding.
    always_comb begin
        fwd_rs_e = 2'd0;
        fwd_rt_e = 2'd0;
        if (hit(eRs_q, mA3_q) && (mTnew_q == 2'd0)) begin
            fwd_rs_e = 2'd1;
        end else if (hit(eRs_q, wA3_q)) begin
            fwd_rs_e = 2'd2;
        end
        if (hit(eRt_q, mA3_q) && (mTnew_q == 2'd0)) begin
            fwd_rt_e = 2'd1;
        end else if (hit(eRt_q, wA3_q)) begin
            fwd_rt_e = 2'd2;
        end
        fwd_rt_m = hit(mRt_q, wA3_q);
    end

    // Next E-slot contents. A stalled cycle injects an all-zero bubble.
    always_comb begin
        eA3_d   = a3D;
        eTnew_d = tnewD;
        eRs_d   = rsD;
        eRt_d   = rtD;
        if (stall) begin
            eA3_d   = 5'd0;
            eTnew_d = 2'd0;
            eRs_d   = 5'd0;
            eRt_d   = 5'd0;
        end
    end

    // The slot pipeline advances every cycle. Reset clears it immediately, so
    // a pending stall drops without waiting for a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            eA3_q   <= 5'd0;
            eTnew_q <= 2'd0;
            eRs_q   <= 5'd0;
            eRt_q   <= 5'd0;
            mA3_q   <= 5'd0;
            mTnew_q <= 2'd0;
            mRt_q   <= 5'd0;
            wA3_q   <= 5'd0;
        end else begin
            eA3_q   <= eA3_d;
            eTnew_q <= eTnew_d;
            eRs_q   <= eRs_d;
            eRt_q   <= eRt_d;
            mA3_q   <= eA3_q;
            mTnew_q <= satDec(eTnew_q);
            mRt_q   <= eRt_q;
            wA3_q   <= mA3_q;
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stallCnt_q;

    // Counts stalled cycles. The count wraps naturally at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stallCnt_q <= 32'd0;
        end else if (stall) begin
            stallCnt_q <= stallCnt_q + 32'd1;
        end
    end

    assign stall_cnt = stallCnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_unit
//
// Runs short instruction sequences through hazard_unit. For each cycle, the
// expected {stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m} vector
// is queued as the instruction is driven. It is popped and compared on the
// falling edge of that cycle. The F/D register is frozen by hand: a stalled
// instruction is simply listed again in the next step.
// ---------------------------------------------------------------------------
module tb_hazard_unit;

    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;
    localparam logic [5:0] FN_JR     = 6'h08;
    localparam logic [5:0] FN_ADD    = 6'h20;
    localparam logic [5:0] FN_SUB    = 6'h22;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr_d = 32'd0;
    logic        stall;
    logic [1:0]  fwd_rs_d;
    logic [1:0]  fwd_rt_d;
    logic [1:0]  fwd_rs_e;
    logic [1:0]  fwd_rt_e;
    logic        fwd_rt_m;
`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int errors = 0;
    int checks = 0;
    logic [9:0] sbQ[$];

    hazard_unit dut (
        .clk      (clk),
        .reset    (reset),
        .instr_d  (instr_d),
        .stall    (stall),
        .fwd_rs_d (fwd_rs_d),
        .fwd_rt_d (fwd_rt_d),
        .fwd_rs_e (fwd_rs_e),
        .fwd_rt_e (fwd_rt_e),
        .fwd_rt_m (fwd_rt_m)
`ifdef HAZARD_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    // 10-unit clock, first rising edge at time 5.
    always #5 clk = ~clk;

    function automatic logic [31:0] encR(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] encI(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [9:0] ev(input logic s, input logic [1:0] rsd, input logic [1:0] rtd,
                                      input logic [1:0] rse, input logic [1:0] rte, input logic rtm);
        return {s, rsd, rtd, rse, rte, rtm};
    endfunction

    function automatic logic [9:0] outVec();
        return {stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m};
    endfunction

    // Drive one F/D instruction and queue the outputs expected for it.
    task automatic applyStimulus(input logic [31:0] instr, input logic [9:0] expv);
        instr_d = instr;
        sbQ.push_back(expv);
    endtask

    // Clears the DUT and leaves the bench just after a rising edge.
    task automatic doReset();
        instr_d = NOP;
        reset   = 1'b1;
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [9:0] expected;
        logic [9:0] observed;
        applyStimulus(encR(5'd1, 5'd1, 5'd2, FN_ADD), ev(0, 0, 0, 0, 0, 0));
        @(negedge clk);
        expected = sbQ.pop_front();
        observed = outVec();
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b, required %b", observed, expected);
        end
`ifdef HAZARD_STALL_CNT_EN
        checks++;
        if (stall_cnt !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_stall_cnt: got %0d, required 0", stall_cnt);
        end
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // lw $1 -> add $2,$1,$1 then lw $1 -> beq $1,$0
    task automatic test_load_use();
        logic [31:0] prog [8];
        logic [9:0]  expv [8];
        logic [9:0]  expected;
        logic [9:0]  observed;
        prog = '{encI(OP_LW, 5'd0, 5'd1, 16'd0), encR(5'd1, 5'd1, 5'd2, FN_ADD),
                 encR(5'd1, 5'd1, 5'd2, FN_ADD), NOP,
                 encI(OP_LW, 5'd0, 5'd1, 16'd0), encI(OP_BEQ, 5'd1, 5'd0, 16'd4),
                 encI(OP_BEQ, 5'd1, 5'd0, 16'd4), encI(OP_BEQ, 5'd1, 5'd0, 16'd4)};
        expv = '{ev(0, 0, 0, 0, 0, 0), ev(1, 0, 0, 0, 0, 0),
                 ev(0, 0, 0, 0, 0, 0), ev(0, 0, 0, 2, 2, 0),
                 ev(0, 0, 0, 0, 0, 0), ev(1, 0, 0, 0, 0, 0),
                 ev(1, 0, 0, 0, 0, 0), ev(0, 0, 0, 0, 0, 0)};
        doReset();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(prog[i], expv[i]);
            @(negedge clk);
            expected = sbQ.pop_front();
            observed = outVec();
            checks++;
            if (observed !== expected) begin
                errors++;
                $display("[TB] FAIL load_use[%0d]: got %b, required %b", i, observed, expected);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // ori $3,$0,5 -> beq $3,$3: one stall, then both operands from M
    task automatic test_alu_branch();
        logic [31:0] prog [3];
        logic [9:0]  expv [3];
        logic [9:0]  expected;
        logic [9:0]  observed;
        prog = '{encI(OP_ORI, 5'd0, 5'd3, 16'd5), encI(OP_BEQ, 5'd3, 5'd3, 16'd2),
                 encI(OP_BEQ, 5'd3, 5'd3, 16'd2)};
        expv = '{ev(0, 0, 0, 0, 0, 0), ev(1, 0, 0, 0, 0, 0), ev(0, 2, 2, 0, 0, 0)};
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(prog[i], expv[i]);
            @(negedge clk);
            expected = sbQ.pop_front();
            observed = outVec();
            checks++;
            if (observed !== expected) begin
                errors++;
                $display("[TB] FAIL alu_branch[%0d]: got %b, required %b", i, observed, expected);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // jal -> jr $31, then add $4 -> sw $4 reaching M with add in W
    task automatic test_link_forward();
        logic [31:0] prog [6];
        logic [9:0]  expv [6];
        logic [9:0]  expected;
        logic [9:0]  observed;
        prog = '{encI(OP_JAL, 5'd0, 5'd0, 16'd0), encR(5'd31, 5'd0, 5'd0, FN_JR),
                 encR(5'd5, 5'd6, 5'd4, FN_ADD), encI(OP_SW, 5'd0, 5'd4, 16'd0),
                 NOP, NOP};
        expv = '{ev(0, 0, 0, 0, 0, 0), ev(0, 1, 0, 0, 0, 0),
                 ev(0, 0, 0, 1, 0, 0), ev(0, 0, 0, 0, 0, 0),
                 ev(0, 0, 0, 0, 1, 0), ev(0, 0, 0, 0, 0, 1)};
        doReset();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(prog[i], expv[i]);
            @(negedge clk);
            expected = sbQ.pop_front();
            observed = outVec();
            checks++;
            if (observed !== expected) begin
                errors++;
                $display("[TB] FAIL link_forward[%0d]: got %b, required %b", i, observed, expected);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // bgezal $7 -> beq $31,$31 (no stall, E link forward), add $5 -> beq $5,$0
    task automatic test_bgezal();
        logic [31:0] prog [5];
        logic [9:0]  expv [5];
        logic [9:0]  expected;
        logic [9:0]  observed;
        prog = '{encI(OP_REGIMM, 5'd7, 5'd17, 16'd3), encI(OP_BEQ, 5'd31, 5'd31, 16'd1),
                 encR(5'd0, 5'd0, 5'd5, FN_ADD), encI(OP_BEQ, 5'd5, 5'd0, 16'd1),
                 encI(OP_BEQ, 5'd5, 5'd0, 16'd1)};
        expv = '{ev(0, 0, 0, 0, 0, 0), ev(0, 1, 1, 0, 0, 0),
                 ev(0, 0, 0, 1, 1, 0), ev(1, 0, 0, 0, 0, 1),
                 ev(0, 2, 0, 0, 0, 0)};
        doReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(prog[i], expv[i]);
            @(negedge clk);
            expected = sbQ.pop_front();
            observed = outVec();
            checks++;
            if (observed !== expected) begin
                errors++;
                $display("[TB] FAIL bgezal[%0d]: got %b, required %b", i, observed, expected);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Writes to $0 never stall or forward; sub result reaches E and M forwards
    task automatic test_zero_reg();
        logic [31:0] prog [5];
        logic [9:0]  expv [5];
        logic [9:0]  expected;
        logic [9:0]  observed;
        prog = '{encI(OP_LW, 5'd0, 5'd0, 16'd0), encR(5'd0, 5'd0, 5'd2, FN_ADD),
                 encR(5'd2, 5'd2, 5'd0, FN_SUB), encR(5'd0, 5'd0, 5'd3, FN_ADD), NOP};
        expv = '{ev(0, 0, 0, 0, 0, 0), ev(0, 0, 0, 0, 0, 0),
                 ev(0, 0, 0, 0, 0, 0), ev(0, 0, 0, 1, 1, 0),
                 ev(0, 0, 0, 0, 0, 1)};
        doReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(prog[i], expv[i]);
            @(negedge clk);
            expected = sbQ.pop_front();
            observed = outVec();
            checks++;
            if (observed !== expected) begin
                errors++;
                $display("[TB] FAIL zero_reg[%0d]: got %b, required %b", i, observed, expected);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Reset asserted between clock edges while lw is in E and its consumer in D
    task automatic test_reset_midflight();
        logic [31:0] addInstr;
        logic [9:0]  expected;
        logic [9:0]  observed;
        addInstr = encR(5'd1, 5'd1, 5'd2, FN_ADD);
        doReset();
        applyStimulus(encI(OP_LW, 5'd0, 5'd1, 16'd0), ev(0, 0, 0, 0, 0, 0));
        @(negedge clk);
        expected = sbQ.pop_front();
        observed = outVec();
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL midreset_lw: got %b, required %b", observed, expected);
        end
        @(posedge clk);
        #1;
        applyStimulus(addInstr, ev(1, 0, 0, 0, 0, 0));
        @(negedge clk);
        expected = sbQ.pop_front();
        observed = outVec();
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL midreset_before: got %b, required %b", observed, expected);
        end
        #2;
        reset = 1'b1;
        applyStimulus(addInstr, ev(0, 0, 0, 0, 0, 0));
        #1;
        expected = sbQ.pop_front();
        observed = outVec();
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL midreset_async: got %b, required %b", observed, expected);
        end
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(NOP, ev(0, 0, 0, 0, 0, 0));
        @(negedge clk);
        expected = sbQ.pop_front();
        observed = outVec();
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL midreset_after: got %b, required %b", observed, expected);
        end
        @(posedge clk);
        #1;
    endtask

`ifdef HAZARD_STALL_CNT_EN
    // Two load-use stalls plus one ALU-branch stall give a count of 3
    task automatic test_stall_cnt();
        logic [31:0] prog [8];
        prog = '{encI(OP_LW, 5'd0, 5'd1, 16'd0), encI(OP_BEQ, 5'd1, 5'd0, 16'd4),
                 encI(OP_BEQ, 5'd1, 5'd0, 16'd4), encI(OP_BEQ, 5'd1, 5'd0, 16'd4),
                 encI(OP_ORI, 5'd0, 5'd3, 16'd5), encI(OP_BEQ, 5'd3, 5'd3, 16'd2),
                 encI(OP_BEQ, 5'd3, 5'd3, 16'd2), NOP};
        doReset();
        @(negedge clk);
        checks++;
        if (stall_cnt !== 32'd0) begin
            errors++;
            $display("[TB] FAIL stall_cnt_clear: got %0d, required 0", stall_cnt);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            instr_d = prog[i];
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checks++;
        if (stall_cnt !== 32'd3) begin
            errors++;
            $display("[TB] FAIL stall_cnt_total: got %0d, required 3", stall_cnt);
        end
    endtask
`endif

    initial begin
        $display("[TB] hazard_unit bench starting");
        test_reset();
        test_load_use();
        test_alu_branch();
        test_link_forward();
        test_bgezal();
        test_zero_reg();
        test_reset_midflight();
`ifdef HAZARD_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
